// File: rtl/speck_encrypt_core.sv
// speck_encrypt_core
//   SPECK128/128 encryption datapath plus round controller. Applies one SPECK
//   round per cycle in ROUND, and between rounds asks the external
//   key_schedule block for the next round key.
//
// Ports
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      block-in handshake; pt_in = {x,y}, key_in = {K,L}
//   out_valid/out_ready    block-out handshake; ct_out = {x,y} after all rounds
//   ks_key, ks_round_ctr   key state and round index presented to key_schedule
//   ks_start               one-cycle request pulse to key_schedule
//   ks_out_key             next key state {K,L} from key_schedule
//   ks_finished            key_schedule done; only a 0->1 edge in KS_WAIT counts
//   state_dbg              current FSM state, debug only
module speck_encrypt_core #(
  parameter int BLOCK_SIZE = 64,
  parameter int KEY_SIZE   = 128,
  parameter int NUM_ROUNDS = 32,
  parameter int ALPHA      = 8,
  parameter int BETA       = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*BLOCK_SIZE-1:0] pt_in,
  input  logic [KEY_SIZE-1:0]     key_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*BLOCK_SIZE-1:0] ct_out,
  output logic [KEY_SIZE-1:0]     ks_key,
  output logic [BLOCK_SIZE-1:0]   ks_round_ctr,
  output logic                    ks_start,
  input  logic [KEY_SIZE-1:0]     ks_out_key,
  input  logic                    ks_finished,
  output logic [2:0]              state_dbg
);

  localparam int RND_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ROUND   = 3'd1,
    KS_REQ  = 3'd2,
    KS_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                  state, state_nxt;
  logic [BLOCK_SIZE-1:0]   x, y;
  logic [KEY_SIZE-1:0]     kstate;
  logic [RND_W-1:0]        rnd;
  logic                    ks_fin_d;

  logic [BLOCK_SIZE-1:0]   rk, x_ror, y_rol, x_nxt, y_nxt;
  logic [RND_W-1:0]        rnd_prev;
  logic                    accept, ks_edge, last_rnd, out_fire;

  // One SPECK round on the current state; the sum wraps mod 2^BLOCK_SIZE.
  assign rk       = kstate[KEY_SIZE-1 -: BLOCK_SIZE];
  assign x_ror    = (x >> ALPHA) | (x << (BLOCK_SIZE - ALPHA));
  assign y_rol    = (y << BETA) | (y >> (BLOCK_SIZE - BETA));
  assign x_nxt    = (x_ror + y) ^ rk;
  assign y_nxt    = y_rol ^ x_nxt;

  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign last_rnd = (rnd == LAST_RND);
  // key_schedule is not reset, so a finished level left over from an earlier
  // request must not be mistaken for completion: only a fresh edge counts.
  assign ks_edge  = ks_finished & ~ks_fin_d;
  // rnd has already advanced past the round just applied when KS_REQ runs.
  assign rnd_prev = rnd - RND_W'(1);

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = ROUND;
      ROUND:   state_nxt = last_rnd ? DONE : KS_REQ;
      KS_REQ:  state_nxt = KS_WAIT;
      KS_WAIT: if (ks_edge)  state_nxt = ROUND;
      DONE:    if (out_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      ks_start     <= 1'b0;
      ct_out       <= '0;
      ks_key       <= '0;
      ks_round_ctr <= '0;
      rnd          <= '0;
      x            <= '0;
      y            <= '0;
      kstate       <= '0;
      ks_fin_d     <= 1'b0;
    end else begin
      ks_fin_d <= ks_finished;
      ks_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            x        <= pt_in[2*BLOCK_SIZE-1 -: BLOCK_SIZE];
            y        <= pt_in[BLOCK_SIZE-1:0];
            kstate   <= key_in;
            rnd      <= '0;
            in_ready <= 1'b0;
          end
        end
        ROUND: begin
          x <= x_nxt;
          y <= y_nxt;
          if (last_rnd) begin
            ct_out    <= {x_nxt, y_nxt};
            out_valid <= 1'b1;
          end else begin
            rnd <= rnd + RND_W'(1);
          end
        end
        KS_REQ: begin
          ks_key       <= kstate;
          ks_round_ctr <= {{(BLOCK_SIZE-RND_W){1'b0}}, rnd_prev};
          ks_start     <= 1'b1;
        end
        KS_WAIT: begin
          if (ks_edge) kstate <= ks_out_key;
        end
        DONE: begin
          if (out_fire) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_speck_encrypt_core.sv
// Bench for speck_encrypt_core: a behavioural key_schedule responder with
// random latency, plus a whole-block SPECK128/128 reference model.
module tb_speck_encrypt_core;

  localparam logic [127:0] K1  = 128'h0706050403020100_0f0e0d0c0b0a0908;
  localparam logic [127:0] PT1 = 128'h6c61766975716520_7469206564616d20;
  localparam logic [127:0] CT1 = 128'ha65d985179783265_7860fedf5c570d18;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, ks_start, ks_finished;
  logic [127:0] pt_in, key_in, ct_out, ks_key, ks_out_key;
  logic [63:0]  ks_round_ctr;
  logic [2:0]   state_dbg;

  speck_encrypt_core dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .pt_in(pt_in), .key_in(key_in),
    .out_valid(out_valid), .out_ready(out_ready), .ct_out(ct_out),
    .ks_key(ks_key), .ks_round_ctr(ks_round_ctr), .ks_start(ks_start),
    .ks_out_key(ks_out_key), .ks_finished(ks_finished),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_start = 0;
  int          n_hs = 0;
  logic [63:0] ctr_q[$];
  bit          stale_mode = 1'b0;

  always @(posedge clk) if (out_valid && out_ready) n_hs++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [63:0] rol64(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  // key_schedule step: {K,L},i -> {K',L'}
  function automatic logic [127:0] ks_step(input logic [127:0] key, input logic [63:0] i);
    logic [63:0] k, l;
    k = key[127:64];
    l = key[63:0];
    l = (k + ror64(l, 8)) ^ i;
    k = rol64(k, 3) ^ l;
    return {k, l};
  endfunction

  // Full-block reference: expand all round keys first, then encrypt.
  function automatic logic [127:0] speck_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [63:0]  rk[32];
    logic [127:0] ks;
    logic [63:0]  x, y;
    ks = key;
    for (int i = 0; i < 32; i++) begin
      rk[i] = ks[127:64];
      ks    = ks_step(ks, 64'(i));
    end
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 32; i++) begin
      x = (ror64(x, 8) + y) ^ rk[i];
      y = rol64(y, 3) ^ x;
    end
    return {x, y};
  endfunction

  // key_schedule responder. Normal mode: finished low for 1..4 cycles, then a
  // one-cycle pulse. Stale mode: finished sits high with a junk key, and only
  // after a delay drops for one cycle and rises with the real key.
  initial begin
    logic [127:0] k;
    logic [63:0]  c;
    int           d;
    ks_finished = 1'b0;
    ks_out_key  = '0;
    forever begin
      @(posedge clk); #1;
      if (ks_start && rst_n) begin
        k = ks_key;
        c = ks_round_ctr;
        n_start++;
        ctr_q.push_back(c);
        d = $urandom_range(1, 4);
        if (stale_mode) begin
          ks_out_key  = {$urandom, $urandom, $urandom, $urandom};
          ks_finished = 1'b1;
          repeat (d) begin @(posedge clk); #1; end
          ks_finished = 1'b0;
          @(posedge clk); #1;
          ks_out_key  = ks_step(k, c);
          ks_finished = 1'b1;
        end else begin
          ks_finished = 1'b0;
          repeat (d) begin @(posedge clk); #1; end
          ks_out_key  = ks_step(k, c);
          ks_finished = 1'b1;
          @(posedge clk); #1;
          ks_finished = 1'b0;
          ks_out_key  = {$urandom, $urandom, $urandom, $urandom};
        end
      end else if (stale_mode) begin
        ks_finished = 1'b1;
      end
    end
  end

  task automatic send(input logic [127:0] pt, input logic [127:0] key);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    check("in_ready_before_send", in_ready, 1);
    pt_in    = pt;
    key_in   = key;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    pt_in    = {$urandom, $urandom, $urandom, $urandom};
    key_in   = {$urandom, $urandom, $urandom, $urandom};
    check("in_ready_low_after_accept", in_ready, 0);
  endtask

  task automatic recv(input int hold, output logic [127:0] ct);
    int n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 3000) begin @(negedge clk); n++; end
    check("out_valid_within_bound", out_valid, 1);
    ct = ct_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_ct_stable", ct_out, ct);
      check("bp_out_valid_held", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_cleared", out_valid, 0);
    check("in_ready_after_out", in_ready, 1);
    check("state_idle_after_out", state_dbg, 0);
  endtask

  task automatic check_ctrs(input string tag);
    check({tag, "_start_count"}, n_start, 31);
    check({tag, "_ctr_count"}, ctr_q.size(), 31);
    for (int i = 0; i < ctr_q.size() && i < 31; i++)
      check({tag, "_ctr_seq"}, ctr_q[i], i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_ks_start"}, ks_start, 0);
    check({tag, "_ct_out"}, ct_out, 0);
    check({tag, "_ks_key"}, ks_key, 0);
    check({tag, "_ks_round_ctr"}, ks_round_ctr, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin
    logic [127:0] ct, pt, key;
    int           h0, n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pt_in     = '0;
    key_in    = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1. standard vector
    n_start = 0; ctr_q.delete();
    send(PT1, K1);
    recv(0, ct);
    check("vec1_ct", ct, CT1);
    check_ctrs("vec1");

    // 2. backpressure with random block
    pt  = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    send(pt, key);
    recv(20, ct);
    check("bp_ct", ct, speck_ref(pt, key));

    // 3. in_valid toggling while busy
    send(PT1, K1);
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      pt_in    = {$urandom, $urandom, $urandom, $urandom};
      key_in   = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (i % 10 == 0) check("busy_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    recv(0, ct);
    check("busy_ct", ct, CT1);

    // 4. reset during the KS_WAIT of round 10
    send(PT1, K1);
    n = 0;
    while (!(state_dbg == 3'd3 && ks_round_ctr == 64'd9) && n < 2000) begin
      @(negedge clk); n++;
    end
    check("reach_round10_wait", state_dbg, 3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    repeat (8) begin
      @(negedge clk);
      check("reset_hold_no_out_valid", out_valid, 0);
    end
    rst_n = 1'b1;
    send(PT1, K1);
    recv(0, ct);
    check("after_reset_ct", ct, CT1);

    // 5. stale finished level entering KS_WAIT
    stale_mode = 1'b1;
    repeat (3) @(negedge clk);
    n_start = 0; ctr_q.delete();
    send(PT1, K1);
    recv(0, ct);
    check("stale_ct", ct, CT1);
    check_ctrs("stale");
    stale_mode = 1'b0;
    repeat (3) @(negedge clk);

    // 6. back-to-back blocks
    h0 = n_hs;
    send(PT1, K1);
    recv(0, ct);
    check("b2b_first_ct", ct, CT1);
    send('0, '0);
    recv(0, ct);
    check("b2b_zero_ct", ct, speck_ref('0, '0));
    check("b2b_handshakes", n_hs - h0, 2);

    // extra random blocks
    for (int t = 0; t < 3; t++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      send(pt, key);
      recv($urandom_range(0, 3), ct);
      check("rand_ct", ct, speck_ref(pt, key));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
